traffic_corridor_ctrl: RTL and testbench
========================================

# traffic_corridor_ctrl

Parametrised controller for a corridor of NUM_X two-way intersections, driven by the 50 MHz board clock. It generates its own timebase tick, sequences north/west vehicle and pedestrian lights per intersection, and staggers intersection start times to form a green wave. Pedestrian requests are latched and served on the next matching green. It supersedes the fixed two-intersection top-level sequencing and sits directly behind the debounce blocks.

## Interface
- NUM_X, 2, number of intersections (1..16)
- CLK_DIV, 50_000_000, clk_50_mhz cycles per tick (≥2)
- GRN_TICKS, 10, green duration in ticks (≥1)
- YLW_TICKS, 3, yellow duration in ticks (≥1)
- ALL_RED_TICKS, 1, all-red clearance in ticks (≥1)
- WALK_TICKS, 6, walk duration in ticks; the effective value is min(WALK_TICKS, GRN_TICKS)
- OFFSET_TICKS, 2, start stagger between adjacent intersections in ticks (≥0)
- clk_50_mhz  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- ped_req_nrth  in  NUM_X  debounced, active-high north crosswalk request; bit i is intersection i
- ped_req_west  in  NUM_X  debounced, active-high west crosswalk request
- red_nrth, ylw_nrth, grn_nrth  out  NUM_X  north vehicle lights
- red_west, ylw_west, grn_west  out  NUM_X  west vehicle lights
- walk_nrth, stop_nrth, walk_west, stop_west  out  NUM_X  pedestrian lights
- tick_out  out  1  one-cycle timebase pulse (debug)

## Operation
- Prescaler: counter of width $clog2(CLK_DIV) counts 0..CLK_DIV-1 and wraps. tick is high during the cycle where count==CLK_DIV-1.
- One independent FSM per intersection i. Each FSM has a phase counter wide enough for max(GRN, YLW, ALL_RED+(NUM_X-1)*OFFSET) ticks.
- States and hold durations in ticks:
  - START: ALL_RED_TICKS + i*OFFSET_TICKS
  - N_GRN: GRN
  - N_YLW: YLW
  - N_RED: ALL_RED
  - W_GRN: GRN
  - W_YLW: YLW
  - W_RED: ALL_RED
- Transitions: START→N_GRN→N_YLW→N_RED→W_GRN→W_YLW→W_RED→N_GRN.
- The FSM and phase counter advance only on tick cycles. A state is left on the tick where the phase counter equals duration-1. The counter clears on entry.
- Vehicle lights: exactly one of red/ylw/grn is high per direction at all times.
  - North is green in N_GRN and yellow in N_YLW; red otherwise.
  - West is green in W_GRN and yellow in W_YLW; red otherwise.
  - North and west are never both non-red.
- Request latch: one per direction per intersection. It sets in any cycle its ped_req bit is high. On entry to the matching green state it is copied into a serve flag and cleared. If the request is high in the entry cycle, set wins and the latch stays set for the following phase.
- Walk: walk_x is high for the first min(WALK_TICKS, GRN_TICKS) ticks of the matching green, only when the serve flag is set. stop_x = ~walk_x always.
- Walk is never high outside the matching green state.
- All light outputs are registered.

## Timing
- Reset values (async, while reset_n=0): all red=1, ylw=0, grn=0, walk=0, stop=1, tick_out=0, prescaler=0, FSMs in START, latches=0.
- Cycle 0 is the first rising edge with reset_n=1. Ticks occur in cycles CLK_DIV-1, 2·CLK_DIV-1, and so on.
- A state change decided on a tick is visible on outputs from the next cycle, i.e. at a multiple of CLK_DIV.
- Intersection i first shows north green at cycle CLK_DIV·(ALL_RED_TICKS + i·OFFSET_TICKS).
- Cycle period is 2·(GRN+YLW+ALL_RED)·CLK_DIV clock cycles.
- A request arriving during a matching green that is already in progress is held for the next matching green, not the current one.
- Reset asserted mid-operation forces reset values immediately and drops pending requests. On release, the startup sequence restarts at START with the stagger.
- With OFFSET_TICKS=0, all intersections are phase-locked.

## Test plan
Parameters for all scenarios: NUM_X=2, CLK_DIV=4, GRN=5, YLW=2, ALL_RED=1, WALK=3, OFFSET=2.
- Reset then idle:
  - X0: grn_nrth[0] high in cycles 4–23, ylw 24–31, red 32–35, grn_west[0] 36–55; repeats every 64 cycles.
  - X1: grn_nrth[1] first high at cycle 12.
- Pulse ped_req_nrth[0] for 1 cycle at cycle 2 → walk_nrth[0] high in cycles 4–15, stop_nrth[0] low over the same span; walk_nrth[1] stays 0.
- Pulse ped_req_west[1] at cycle 20 (during X1 north green) → walk_west[1] high for 12 cycles starting at the X1 west-green entry, cycle 44.
- Pulse ped_req_nrth[0] at cycle 6 (mid north green) → no walk in 4–23; walk_nrth[0] high 68–79.
- Assert reset_n=0 at cycle 30 for 3 cycles → all outputs return to reset values within the same cycle; after release, X0 north green at 4 cycles and X1 at 12 cycles post-release.
- Every cycle across all scenarios: one-hot lights per direction, never both directions non-red, walk implies matching green, stop = ~walk.

Source files
------------

// File: rtl/traffic_corridor_ctrl.sv
// Corridor light controller: a shared tick prescaler plus one staggered
// north/west sequencing FSM per intersection, with latched pedestrian requests.
module traffic_corridor_ctrl #(
   parameter int NUM_X         = 2,
   parameter int CLK_DIV       = 50_000_000,
   parameter int GRN_TICKS     = 10,
   parameter int YLW_TICKS     = 3,
   parameter int ALL_RED_TICKS = 1,
   parameter int WALK_TICKS    = 6,
   parameter int OFFSET_TICKS  = 2
) (
   input  logic             clk_50_mhz,
   input  logic             reset_n,
   input  logic [NUM_X-1:0] ped_req_nrth,
   input  logic [NUM_X-1:0] ped_req_west,
   output logic [NUM_X-1:0] red_nrth,
   output logic [NUM_X-1:0] ylw_nrth,
   output logic [NUM_X-1:0] grn_nrth,
   output logic [NUM_X-1:0] red_west,
   output logic [NUM_X-1:0] ylw_west,
   output logic [NUM_X-1:0] grn_west,
   output logic [NUM_X-1:0] walk_nrth,
   output logic [NUM_X-1:0] stop_nrth,
   output logic [NUM_X-1:0] walk_west,
   output logic [NUM_X-1:0] stop_west,
   output logic             tick_out
);
   localparam logic [2:0] ST_START = 3'd0;
   localparam logic [2:0] ST_N_GRN = 3'd1;
   localparam logic [2:0] ST_N_YLW = 3'd2;
   localparam logic [2:0] ST_N_RED = 3'd3;
   localparam logic [2:0] ST_W_GRN = 3'd4;
   localparam logic [2:0] ST_W_YLW = 3'd5;
   localparam logic [2:0] ST_W_RED = 3'd6;

   localparam int CNT_W     = $clog2(CLK_DIV);
   localparam int START_MAX = ALL_RED_TICKS + (NUM_X - 1) * OFFSET_TICKS;
   localparam int PH_MAX_A  = (GRN_TICKS > YLW_TICKS) ? GRN_TICKS : YLW_TICKS;
   localparam int PH_MAX    = (PH_MAX_A > START_MAX) ? PH_MAX_A : START_MAX;
   localparam int PH_W      = $clog2(PH_MAX + 1);
   localparam int WALK_EFF  = (WALK_TICKS < GRN_TICKS) ? WALK_TICKS : GRN_TICKS;

   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nx_s;
   logic             tick_r;

   // Prescaler next count, wrapping at CLK_DIV-1
   always_comb begin
      if (cnt_r == CNT_W'(CLK_DIV - 1)) begin
         cnt_nx_s = {CNT_W{1'b0}};
      end else begin
         cnt_nx_s = cnt_r + CNT_W'(1);
      end
   end

   // Tick is registered from the next count so it lines up with count==CLK_DIV-1
   always_ff @(posedge clk_50_mhz or negedge reset_n) begin
      if (!reset_n) begin
         cnt_r  <= {CNT_W{1'b0}};
         tick_r <= 1'b0;
      end else begin
         cnt_r  <= cnt_nx_s;
         tick_r <= (cnt_nx_s == CNT_W'(CLK_DIV - 1));
      end
   end

   assign tick_out = tick_r;

   for (genvar gi = 0; gi < NUM_X; gi++) begin : g_x
      localparam int START_TICKS = ALL_RED_TICKS + gi * OFFSET_TICKS;

      logic [2:0]      state_r, state_nx_s;
      logic [PH_W-1:0] phase_r, phase_nx_s;
      logic [31:0]     dur_s;
      logic            done_s, enter_n_s, enter_w_s;
      logic            lat_n_r, lat_w_r, serve_n_r, serve_w_r;
      logic            lat_n_nx_s, lat_w_nx_s, serve_n_nx_s, serve_w_nx_s;
      logic            walk_n_nx_s, walk_w_nx_s;
      logic            red_n_r, ylw_n_r, grn_n_r, red_w_r, ylw_w_r, grn_w_r;
      logic            walk_n_r, stop_n_r, walk_w_r, stop_w_r;

      // Hold duration of the current state; START carries the green-wave stagger
      always_comb begin
         case (state_r)
            ST_START:           dur_s = 32'(START_TICKS);
            ST_N_GRN, ST_W_GRN: dur_s = 32'(GRN_TICKS);
            ST_N_YLW, ST_W_YLW: dur_s = 32'(YLW_TICKS);
            default:            dur_s = 32'(ALL_RED_TICKS);
         endcase
      end

      assign done_s = tick_r && (32'(phase_r) == (dur_s - 32'd1));

      // State sequencing and phase counter, both advancing only on ticks
      always_comb begin
         state_nx_s = state_r;
         phase_nx_s = phase_r;
         if (done_s) begin
            phase_nx_s = {PH_W{1'b0}};
            case (state_r)
               ST_START: state_nx_s = ST_N_GRN;
               ST_N_GRN: state_nx_s = ST_N_YLW;
               ST_N_YLW: state_nx_s = ST_N_RED;
               ST_N_RED: state_nx_s = ST_W_GRN;
               ST_W_GRN: state_nx_s = ST_W_YLW;
               ST_W_YLW: state_nx_s = ST_W_RED;
               ST_W_RED: state_nx_s = ST_N_GRN;
               default:  state_nx_s = ST_START;
            endcase
         end else if (tick_r) begin
            phase_nx_s = phase_r + PH_W'(1);
         end else begin
            phase_nx_s = phase_r;
         end
      end

      assign enter_n_s = done_s && (state_nx_s == ST_N_GRN);
      assign enter_w_s = done_s && (state_nx_s == ST_W_GRN);

      // A request in the entry cycle re-arms the latch for the following green
      always_comb begin
         lat_n_nx_s   = ped_req_nrth[gi] | (lat_n_r & ~enter_n_s);
         lat_w_nx_s   = ped_req_west[gi] | (lat_w_r & ~enter_w_s);
         serve_n_nx_s = enter_n_s ? lat_n_r : serve_n_r;
         serve_w_nx_s = enter_w_s ? lat_w_r : serve_w_r;
         walk_n_nx_s  = (state_nx_s == ST_N_GRN) && serve_n_nx_s &&
                        (32'(phase_nx_s) < 32'(WALK_EFF));
         walk_w_nx_s  = (state_nx_s == ST_W_GRN) && serve_w_nx_s &&
                        (32'(phase_nx_s) < 32'(WALK_EFF));
      end

      // State, request latches and registered light outputs
      always_ff @(posedge clk_50_mhz or negedge reset_n) begin
         if (!reset_n) begin
            state_r   <= ST_START;
            phase_r   <= {PH_W{1'b0}};
            lat_n_r   <= 1'b0;
            lat_w_r   <= 1'b0;
            serve_n_r <= 1'b0;
            serve_w_r <= 1'b0;
            red_n_r   <= 1'b1;
            ylw_n_r   <= 1'b0;
            grn_n_r   <= 1'b0;
            red_w_r   <= 1'b1;
            ylw_w_r   <= 1'b0;
            grn_w_r   <= 1'b0;
            walk_n_r  <= 1'b0;
            stop_n_r  <= 1'b1;
            walk_w_r  <= 1'b0;
            stop_w_r  <= 1'b1;
         end else begin
            state_r   <= state_nx_s;
            phase_r   <= phase_nx_s;
            lat_n_r   <= lat_n_nx_s;
            lat_w_r   <= lat_w_nx_s;
            serve_n_r <= serve_n_nx_s;
            serve_w_r <= serve_w_nx_s;
            grn_n_r   <= (state_nx_s == ST_N_GRN);
            ylw_n_r   <= (state_nx_s == ST_N_YLW);
            red_n_r   <= (state_nx_s != ST_N_GRN) && (state_nx_s != ST_N_YLW);
            grn_w_r   <= (state_nx_s == ST_W_GRN);
            ylw_w_r   <= (state_nx_s == ST_W_YLW);
            red_w_r   <= (state_nx_s != ST_W_GRN) && (state_nx_s != ST_W_YLW);
            walk_n_r  <= walk_n_nx_s;
            stop_n_r  <= ~walk_n_nx_s;
            walk_w_r  <= walk_w_nx_s;
            stop_w_r  <= ~walk_w_nx_s;
         end
      end

      assign red_nrth[gi]  = red_n_r;
      assign ylw_nrth[gi]  = ylw_n_r;
      assign grn_nrth[gi]  = grn_n_r;
      assign red_west[gi]  = red_w_r;
      assign ylw_west[gi]  = ylw_w_r;
      assign grn_west[gi]  = grn_w_r;
      assign walk_nrth[gi] = walk_n_r;
      assign stop_nrth[gi] = stop_n_r;
      assign walk_west[gi] = walk_w_r;
      assign stop_west[gi] = stop_w_r;
   end

endmodule

// File: tb/tb_traffic_corridor_ctrl.sv
// Directed bench for traffic_corridor_ctrl: a timeline model predicts every
// output per cycle into a scoreboard queue, popped and compared one cycle later.
module tb_traffic_corridor_ctrl;
   logic       clk_50_mhz = 1'b0;
   logic       reset_n;
   logic [1:0] ped_req_nrth, ped_req_west;
   logic [1:0] red_nrth, ylw_nrth, grn_nrth, red_west, ylw_west, grn_west;
   logic [1:0] walk_nrth, stop_nrth, walk_west, stop_west;
   logic       tick_out;

   int checks = 0;
   int errors = 0;
   logic [20:0] exp_q[$];
   int pn0_a, pn1_a, pw1_a;   // pulse cycles (-1 = none)
   int wn0_a, ww1_a;          // expected walk window starts (-1 = none)

   localparam logic [20:0] RST_VAL = {2'b11, 2'b00, 2'b00, 2'b11, 2'b00, 2'b00,
                                      2'b00, 2'b11, 2'b00, 2'b11, 1'b0};

   traffic_corridor_ctrl #(
      .NUM_X(2), .CLK_DIV(4), .GRN_TICKS(5), .YLW_TICKS(2),
      .ALL_RED_TICKS(1), .WALK_TICKS(3), .OFFSET_TICKS(2)
   ) dut (
      .clk_50_mhz(clk_50_mhz), .reset_n(reset_n),
      .ped_req_nrth(ped_req_nrth), .ped_req_west(ped_req_west),
      .red_nrth(red_nrth), .ylw_nrth(ylw_nrth), .grn_nrth(grn_nrth),
      .red_west(red_west), .ylw_west(ylw_west), .grn_west(grn_west),
      .walk_nrth(walk_nrth), .stop_nrth(stop_nrth),
      .walk_west(walk_west), .stop_west(stop_west),
      .tick_out(tick_out)
   );

   always #10 clk_50_mhz = ~clk_50_mhz;

   function automatic logic in_win(input int t, input int s);
      return (s >= 0) && (t >= s) && (t < s + 12);
   endfunction

   // Expected outputs at cycle t after reset release
   function automatic logic [20:0] model(input int t);
      logic [1:0] rn, yn, gn, rw, yw, gw, wn, ww;
      logic       tk;
      for (int i = 0; i < 2; i++) begin
         int st, p;
         st = 4 * (1 + 2 * i);
         gn[i] = 1'b0; yn[i] = 1'b0; gw[i] = 1'b0; yw[i] = 1'b0;
         if (t >= st) begin
            p = (t - st) % 64;
            gn[i] = (p < 20);
            yn[i] = (p >= 20) && (p < 28);
            gw[i] = (p >= 32) && (p < 52);
            yw[i] = (p >= 52) && (p < 60);
         end
         rn[i] = ~(gn[i] | yn[i]);
         rw[i] = ~(gw[i] | yw[i]);
      end
      wn = {1'b0, in_win(t, wn0_a)};
      ww = {in_win(t, ww1_a), 1'b0};
      tk = ((t % 4) == 3);
      return {rn, yn, gn, rw, yw, gw, wn, ~wn, ww, ~ww, tk};
   endfunction

   function automatic logic [20:0] obs_vec();
      return {red_nrth, ylw_nrth, grn_nrth, red_west, ylw_west, grn_west,
              walk_nrth, stop_nrth, walk_west, stop_west, tick_out};
   endfunction

   task automatic check(input string tag, input logic [20:0] o, input logic [20:0] e);
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic check_inv(input string tag);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 2; i++) begin
         ok &= $onehot({red_nrth[i], ylw_nrth[i], grn_nrth[i]});
         ok &= $onehot({red_west[i], ylw_west[i], grn_west[i]});
         ok &= red_nrth[i] | red_west[i];
         ok &= ~walk_nrth[i] | grn_nrth[i];
         ok &= ~walk_west[i] | grn_west[i];
         ok &= (stop_nrth[i] === ~walk_nrth[i]) && (stop_west[i] === ~walk_west[i]);
      end
      checks++;
      assert (ok === 1'b1) else begin
         errors++;
         $error("FAIL %s invariant observed=%b expected=1", tag, ok);
      end
   endtask

   task automatic do_reset(input string name);
      reset_n = 1'b0;
      ped_req_nrth = 2'b00;
      ped_req_west = 2'b00;
      #1;
      check({name, "_rst_now"}, obs_vec(), RST_VAL);
      repeat (3) @(negedge clk_50_mhz);
      check({name, "_rst_hold"}, obs_vec(), RST_VAL);
      reset_n = 1'b1;
      exp_q.delete();
      exp_q.push_back(model(0));
   endtask

   task automatic run_scenario(input string name, input int ncyc, input int rst_at);
      int c;
      int ra;
      ra = rst_at;
      @(negedge clk_50_mhz);
      do_reset(name);
      c = 0;
      while (c < ncyc) begin
         check($sformatf("%s_c%0d", name, c), obs_vec(), exp_q.pop_front());
         check_inv($sformatf("%s_c%0d", name, c));
         if (c == ra) begin
            pn0_a = -1; pn1_a = -1; pw1_a = -1; wn0_a = -1; ww1_a = -1;
            ra = -1;
            do_reset({name, "_mid"});
            c = 0;
         end else begin
            ped_req_nrth = {(c == pn1_a), (c == pn0_a)};
            ped_req_west = {(c == pw1_a), 1'b0};
            exp_q.push_back(model(c + 1));
            @(negedge clk_50_mhz);
            c++;
         end
      end
      ped_req_nrth = 2'b00;
      ped_req_west = 2'b00;
   endtask

   initial begin
      reset_n = 1'b0;
      ped_req_nrth = 2'b00;
      ped_req_west = 2'b00;

      pn0_a = -1; pn1_a = -1; pw1_a = -1; wn0_a = -1; ww1_a = -1;
      run_scenario("idle", 140, -1);

      pn0_a = 2; pn1_a = -1; pw1_a = 20; wn0_a = 4; ww1_a = 44;
      run_scenario("req", 72, -1);

      pn0_a = 6; pn1_a = -1; pw1_a = -1; wn0_a = 68; ww1_a = -1;
      run_scenario("late", 90, -1);

      pn0_a = -1; pn1_a = 20; pw1_a = -1; wn0_a = -1; ww1_a = -1;
      run_scenario("midrst", 100, 30);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
